// File: rtl/rename_register_file.sv
// Rename register file: per-slot operand read with producer tags, rd rename, N commit ports, flush (RF_CDB_BYPASS_EN adds CDB wakeup).
// Latency: 1 cycle from dispatch inputs to operand outputs; commit data is bypassed into the same-cycle read.
// Backpressure: halt freezes outputs and suppresses rename while commits keep landing; flush overrides halt and dispatch.
module rename_register_file #(
    parameter int IPC        = 2,
    parameter int NUM_COMMIT = 2,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 7,
    parameter int RF_WIDTH   = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             halt,
    input  logic                             flush,
    input  logic [IPC-1:0]                   disp_valid,
    input  logic [IPC*RF_WIDTH-1:0]          rs1,
    input  logic [IPC*RF_WIDTH-1:0]          rs2,
    input  logic [IPC-1:0]                   rd_we,
    input  logic [IPC*RF_WIDTH-1:0]          rd,
    input  logic [IPC*TAG_WIDTH-1:0]         dest_tag,
    output logic [IPC-1:0]                   out_valid,
    output logic [IPC-1:0]                   rs1_ready,
    output logic [IPC*TAG_WIDTH-1:0]         rs1_tag,
    output logic [IPC*DATA_WIDTH-1:0]        rs1_data,
    output logic [IPC-1:0]                   rs2_ready,
    output logic [IPC*TAG_WIDTH-1:0]         rs2_tag,
    output logic [IPC*DATA_WIDTH-1:0]        rs2_data,
    input  logic [NUM_COMMIT-1:0]            commit_valid,
    input  logic [NUM_COMMIT*RF_WIDTH-1:0]   commit_rd,
    input  logic [NUM_COMMIT*TAG_WIDTH-1:0]  commit_tag,
    input  logic [NUM_COMMIT*DATA_WIDTH-1:0] commit_data,
    input  logic                             cdb_valid,
    input  logic [TAG_WIDTH-1:0]             cdb_tag,
    input  logic [DATA_WIDTH-1:0]            cdb_data
);
    localparam int NUM_REGS = 1 << RF_WIDTH;

    logic [DATA_WIDTH-1:0] data_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] data_d [NUM_REGS];
    logic [TAG_WIDTH-1:0]  tag_q  [NUM_REGS];
    logic [TAG_WIDTH-1:0]  tag_d  [NUM_REGS];
    logic [NUM_REGS-1:0]   busy_q, busy_d;

    logic [IPC-1:0]            out_valid_q, out_valid_d;
    logic [IPC-1:0]            rs1_ready_q, rs1_ready_d, rs2_ready_q, rs2_ready_d;
    logic [IPC*TAG_WIDTH-1:0]  rs1_tag_q, rs1_tag_d, rs2_tag_q, rs2_tag_d;
    logic [IPC*DATA_WIDTH-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;

    logic [IPC-1:0]            res1_ready, res2_ready;
    logic [IPC*TAG_WIDTH-1:0]  res1_tag, res2_tag;
    logic [IPC*DATA_WIDTH-1:0] res1_data, res2_data;

    // Tying the enable low lets the default build prune every CDB path.
    logic cdb_en_vld;
`ifdef RF_CDB_BYPASS_EN
    assign cdb_en_vld = cdb_valid;
`else
    logic unused_cdb_valid;
    assign cdb_en_vld       = 1'b0;
    assign unused_cdb_valid = cdb_valid;
`endif

    always_comb begin : resolve
        logic [RF_WIDTH-1:0]   s;
        logic                  r_rdy;
        logic [TAG_WIDTH-1:0]  r_tag;
        logic [DATA_WIDTH-1:0] r_dat;
        s          = '0;
        r_rdy      = 1'b0;
        r_tag      = '0;
        r_dat      = '0;
        res1_ready = '0;
        res1_tag   = '0;
        res1_data  = '0;
        res2_ready = '0;
        res2_tag   = '0;
        res2_data  = '0;
        for (int i = 0; i < IPC; i++) begin
            for (int src = 0; src < 2; src++) begin
                s     = (src == 0) ? rs1[i*RF_WIDTH +: RF_WIDTH] : rs2[i*RF_WIDTH +: RF_WIDTH];
                r_rdy = ~busy_q[s];
                r_tag = tag_q[s];
                r_dat = data_q[s];
                // Lowest priority applied first, each later rule overrides.
                for (int k = 0; k < NUM_COMMIT; k++) begin
                    if (commit_valid[k] && busy_q[s] &&
                        commit_rd[k*RF_WIDTH +: RF_WIDTH] == s &&
                        commit_tag[k*TAG_WIDTH +: TAG_WIDTH] == tag_q[s]) begin
                        r_rdy = 1'b1;
                        r_dat = commit_data[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                for (int j = 0; j < IPC; j++) begin
                    if (j < i && disp_valid[j] && rd_we[j] && rd[j*RF_WIDTH +: RF_WIDTH] == s) begin
                        r_rdy = 1'b0;
                        r_tag = dest_tag[j*TAG_WIDTH +: TAG_WIDTH];
                        r_dat = '0;
                    end
                end
                if (!r_rdy && cdb_en_vld && r_tag == cdb_tag) begin
                    r_rdy = 1'b1;
                    r_dat = cdb_data;
                end
                if (s == '0) begin
                    r_rdy = 1'b1;
                    r_tag = '0;
                    r_dat = '0;
                end
                if (src == 0) begin
                    res1_ready[i]                          = r_rdy;
                    res1_tag[i*TAG_WIDTH +: TAG_WIDTH]     = r_tag;
                    res1_data[i*DATA_WIDTH +: DATA_WIDTH]  = r_dat;
                end else begin
                    res2_ready[i]                          = r_rdy;
                    res2_tag[i*TAG_WIDTH +: TAG_WIDTH]     = r_tag;
                    res2_data[i*DATA_WIDTH +: DATA_WIDTH]  = r_dat;
                end
            end
        end
    end

    always_comb begin : state_next
        data_d = data_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        // Busy clears only for the tag currently owning the register; stale commits just land data.
        for (int k = 0; k < NUM_COMMIT; k++) begin
            if (commit_valid[k] && commit_rd[k*RF_WIDTH +: RF_WIDTH] != '0) begin
                data_d[commit_rd[k*RF_WIDTH +: RF_WIDTH]] = commit_data[k*DATA_WIDTH +: DATA_WIDTH];
                if (busy_q[commit_rd[k*RF_WIDTH +: RF_WIDTH]] &&
                    tag_q[commit_rd[k*RF_WIDTH +: RF_WIDTH]] == commit_tag[k*TAG_WIDTH +: TAG_WIDTH]) begin
                    busy_d[commit_rd[k*RF_WIDTH +: RF_WIDTH]] = 1'b0;
                end
            end
        end
        if (!flush && !halt) begin
            for (int i = 0; i < IPC; i++) begin
                if (disp_valid[i] && rd_we[i] && rd[i*RF_WIDTH +: RF_WIDTH] != '0) begin
                    busy_d[rd[i*RF_WIDTH +: RF_WIDTH]] = 1'b1;
                    tag_d[rd[i*RF_WIDTH +: RF_WIDTH]]  = dest_tag[i*TAG_WIDTH +: TAG_WIDTH];
                end
            end
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    always_comb begin : out_next
        out_valid_d = out_valid_q;
        rs1_ready_d = rs1_ready_q;
        rs1_tag_d   = rs1_tag_q;
        rs1_data_d  = rs1_data_q;
        rs2_ready_d = rs2_ready_q;
        rs2_tag_d   = rs2_tag_q;
        rs2_data_d  = rs2_data_q;
        if (!halt) begin
            out_valid_d = disp_valid;
            rs1_ready_d = res1_ready;
            rs1_tag_d   = res1_tag;
            rs1_data_d  = res1_data;
            rs2_ready_d = res2_ready;
            rs2_tag_d   = res2_tag;
            rs2_data_d  = res2_data;
        end else if (cdb_en_vld) begin
            // Held operands still wake up on a matching broadcast.
            for (int i = 0; i < IPC; i++) begin
                if (!rs1_ready_q[i] && rs1_tag_q[i*TAG_WIDTH +: TAG_WIDTH] == cdb_tag) begin
                    rs1_ready_d[i]                         = 1'b1;
                    rs1_data_d[i*DATA_WIDTH +: DATA_WIDTH] = cdb_data;
                end
                if (!rs2_ready_q[i] && rs2_tag_q[i*TAG_WIDTH +: TAG_WIDTH] == cdb_tag) begin
                    rs2_ready_d[i]                         = 1'b1;
                    rs2_data_d[i*DATA_WIDTH +: DATA_WIDTH] = cdb_data;
                end
            end
        end
        if (flush) begin
            out_valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                data_q[r] <= '0;
                tag_q[r]  <= '0;
            end
            busy_q      <= '0;
            out_valid_q <= '0;
            rs1_ready_q <= '0;
            rs1_tag_q   <= '0;
            rs1_data_q  <= '0;
            rs2_ready_q <= '0;
            rs2_tag_q   <= '0;
            rs2_data_q  <= '0;
        end else begin
            data_q      <= data_d;
            tag_q       <= tag_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            rs1_ready_q <= rs1_ready_d;
            rs1_tag_q   <= rs1_tag_d;
            rs1_data_q  <= rs1_data_d;
            rs2_ready_q <= rs2_ready_d;
            rs2_tag_q   <= rs2_tag_d;
            rs2_data_q  <= rs2_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rs1_ready = rs1_ready_q;
    assign rs1_tag   = rs1_tag_q;
    assign rs1_data  = rs1_data_q;
    assign rs2_ready = rs2_ready_q;
    assign rs2_tag   = rs2_tag_q;
    assign rs2_data  = rs2_data_q;
endmodule

// File: tb/tb_rename_register_file.sv
// Directed bench for rename_register_file: reset, rename, commit bypass, stale commit, bundle deps, halt, flush, CDB.
module tb_rename_register_file;
    logic        clk;
    logic        rst_n;
    logic        halt;
    logic        flush;
    logic [1:0]  disp_valid;
    logic [9:0]  rs1, rs2, rd;
    logic [1:0]  rd_we;
    logic [13:0] dest_tag;
    logic [1:0]  out_valid, rs1_ready, rs2_ready;
    logic [13:0] rs1_tag, rs2_tag;
    logic [63:0] rs1_data, rs2_data;
    logic [1:0]  commit_valid;
    logic [9:0]  commit_rd;
    logic [13:0] commit_tag;
    logic [63:0] commit_data;
    logic        cdb_valid;
    logic [6:0]  cdb_tag;
    logic [31:0] cdb_data;

    int n_cmp;
    int n_fail;

    rename_register_file dut (
        .clk(clk), .rst_n(rst_n), .halt(halt), .flush(flush),
        .disp_valid(disp_valid), .rs1(rs1), .rs2(rs2), .rd_we(rd_we), .rd(rd), .dest_tag(dest_tag),
        .out_valid(out_valid), .rs1_ready(rs1_ready), .rs1_tag(rs1_tag), .rs1_data(rs1_data),
        .rs2_ready(rs2_ready), .rs2_tag(rs2_tag), .rs2_data(rs2_data),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag), .commit_data(commit_data),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        halt = 0; flush = 0; disp_valid = '0; rs1 = '0; rs2 = '0; rd = '0; rd_we = '0; dest_tag = '0;
        commit_valid = '0; commit_rd = '0; commit_tag = '0; commit_data = '0;
        cdb_valid = 0; cdb_tag = '0; cdb_data = '0;
    endtask

    task automatic disp(input int i, input logic [4:0] r1, input logic [4:0] r2,
                        input logic we, input logic [4:0] rdv, input logic [6:0] tg);
        disp_valid[i] = 1'b1;
        rs1[i*5 +: 5] = r1;
        rs2[i*5 +: 5] = r2;
        rd_we[i] = we;
        rd[i*5 +: 5] = rdv;
        dest_tag[i*7 +: 7] = tg;
    endtask

    task automatic commit(input int k, input logic [4:0] rdv, input logic [6:0] tg, input logic [31:0] dat);
        commit_valid[k] = 1'b1;
        commit_rd[k*5 +: 5] = rdv;
        commit_tag[k*7 +: 7] = tg;
        commit_data[k*32 +: 32] = dat;
    endtask

    task automatic test_reset;
        idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({out_valid, rs1_ready, rs1_tag, rs1_data, rs2_ready, rs2_tag, rs2_data} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", {out_valid, rs1_ready, rs1_tag, rs1_data, rs2_ready, rs2_tag, rs2_data});
        end
        rst_n = 1'b1;
        disp(0, 5'd0, 5'd0, 1'b1, 5'd5, 7'h33);
        tick();
        n_cmp++;
        if (out_valid !== 2'b01) begin n_fail++; $display("FAIL reset_pre_valid: got %b want 01", out_valid); end
        idle();
        disp(0, 5'd5, 5'd0, 1'b0, 5'd0, 7'h0);
        disp(1, 5'd5, 5'd0, 1'b0, 5'd0, 7'h0);
        tick();
        n_cmp++;
        if (rs1_tag !== {7'h33, 7'h33}) begin n_fail++; $display("FAIL reset_pre_tag: got %h want %h", rs1_tag, {7'h33, 7'h33}); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, rs1_ready, rs1_tag, rs1_data, rs2_ready, rs2_tag, rs2_data} !== '0) begin
            n_fail++; $display("FAIL reset_async: got %h want 0", {out_valid, rs1_ready, rs1_tag, rs1_data, rs2_ready, rs2_tag, rs2_data});
        end
        tick();
        rst_n = 1'b1;
        idle();
        disp(0, 5'd5, 5'd0, 1'b0, 5'd0, 7'h0);
        tick();
        n_cmp++;
        if (rs1_ready[0] !== 1'b1 || rs1_data[31:0] !== 32'h0) begin
            n_fail++; $display("FAIL reset_x5_read: got rdy=%b data=%h want rdy=1 data=0", rs1_ready[0], rs1_data[31:0]);
        end
    endtask

    task automatic test_rename;
        idle();
        disp(0, 5'd0, 5'd0, 1'b1, 5'd5, 7'h12);
        tick();
        idle();
        disp(0, 5'd5, 5'd0, 1'b0, 5'd0, 7'h0);
        tick();
        n_cmp++;
        if (rs1_ready[0] !== 1'b0 || rs1_tag[6:0] !== 7'h12) begin
            n_fail++; $display("FAIL rename_rs1: got rdy=%b tag=%h want rdy=0 tag=12", rs1_ready[0], rs1_tag[6:0]);
        end
        n_cmp++;
        if (rs2_ready[0] !== 1'b1 || rs2_data[31:0] !== 32'h0) begin
            n_fail++; $display("FAIL rename_x0_src: got rdy=%b data=%h want rdy=1 data=0", rs2_ready[0], rs2_data[31:0]);
        end
    endtask

    task automatic test_commit;
        idle();
        disp(0, 5'd5, 5'd0, 1'b0, 5'd0, 7'h0);
        commit(0, 5'd5, 7'h12, 32'hDEADBEEF);
        tick();
        n_cmp++;
        if (rs1_ready[0] !== 1'b1 || rs1_data[31:0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL commit_bypass: got rdy=%b data=%h want rdy=1 data=deadbeef", rs1_ready[0], rs1_data[31:0]);
        end
        idle();
        disp(0, 5'd5, 5'd0, 1'b0, 5'd0, 7'h0);
        tick();
        n_cmp++;
        if (rs1_ready[0] !== 1'b1 || rs1_data[31:0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL commit_after: got rdy=%b data=%h want rdy=1 data=deadbeef", rs1_ready[0], rs1_data[31:0]);
        end
    endtask

    task automatic test_stale_commit;
        idle();
        disp(0, 5'd0, 5'd0, 1'b1, 5'd5, 7'h13);
        tick();
        idle();
        disp(0, 5'd5, 5'd0, 1'b0, 5'd0, 7'h0);
        commit(0, 5'd5, 7'h12, 32'h1111);
        tick();
        n_cmp++;
        if (rs1_ready[0] !== 1'b0 || rs1_tag[6:0] !== 7'h13) begin
            n_fail++; $display("FAIL stale_same_cycle: got rdy=%b tag=%h want rdy=0 tag=13", rs1_ready[0], rs1_tag[6:0]);
        end
        idle();
        disp(0, 5'd5, 5'd0, 1'b0, 5'd0, 7'h0);
        tick();
        n_cmp++;
        if (rs1_ready[0] !== 1'b0 || rs1_tag[6:0] !== 7'h13) begin
            n_fail++; $display("FAIL stale_still_busy: got rdy=%b tag=%h want rdy=0 tag=13", rs1_ready[0], rs1_tag[6:0]);
        end
        idle();
        commit(0, 5'd5, 7'h13, 32'h3333);
        commit(1, 5'd5, 7'h13, 32'h2222);
        disp(1, 5'd0, 5'd5, 1'b0, 5'd0, 7'h0);
        tick();
        n_cmp++;
        if (rs2_ready[1] !== 1'b1 || rs2_data[63:32] !== 32'h2222) begin
            n_fail++; $display("FAIL dual_commit_bypass: got rdy=%b data=%h want rdy=1 data=2222", rs2_ready[1], rs2_data[63:32]);
        end
        idle();
        disp(0, 5'd5, 5'd0, 1'b0, 5'd0, 7'h0);
        tick();
        n_cmp++;
        if (rs1_ready[0] !== 1'b1 || rs1_data[31:0] !== 32'h2222) begin
            n_fail++; $display("FAIL dual_commit_write: got rdy=%b data=%h want rdy=1 data=2222", rs1_ready[0], rs1_data[31:0]);
        end
    endtask

    task automatic test_bundle;
        idle();
        disp(0, 5'd0, 5'd0, 1'b1, 5'd7, 7'h20);
        disp(1, 5'd0, 5'd7, 1'b1, 5'd7, 7'h21);
        tick();
        n_cmp++;
        if (rs2_ready[1] !== 1'b0 || rs2_tag[13:7] !== 7'h20) begin
            n_fail++; $display("FAIL bundle_dep: got rdy=%b tag=%h want rdy=0 tag=20", rs2_ready[1], rs2_tag[13:7]);
        end
        n_cmp++;
        if (rs1_ready[1] !== 1'b1 || rs1_data[63:32] !== 32'h0) begin
            n_fail++; $display("FAIL bundle_x0: got rdy=%b data=%h want rdy=1 data=0", rs1_ready[1], rs1_data[63:32]);
        end
        idle();
        disp(0, 5'd7, 5'd0, 1'b0, 5'd0, 7'h0);
        tick();
        n_cmp++;
        if (rs1_ready[0] !== 1'b0 || rs1_tag[6:0] !== 7'h21) begin
            n_fail++; $display("FAIL bundle_high_slot_wins: got rdy=%b tag=%h want rdy=0 tag=21", rs1_ready[0], rs1_tag[6:0]);
        end
        idle();
        disp(0, 5'd0, 5'd0, 1'b1, 5'd0, 7'h7F);
        disp(1, 5'd0, 5'd0, 1'b0, 5'd0, 7'h0);
        tick();
        n_cmp++;
        if (rs1_ready[1] !== 1'b1 || rs1_tag[13:7] !== 7'h0) begin
            n_fail++; $display("FAIL bundle_x0_rename: got rdy=%b tag=%h want rdy=1 tag=0", rs1_ready[1], rs1_tag[13:7]);
        end
    endtask

    task automatic test_halt;
        idle();
        disp(0, 5'd7, 5'd0, 1'b0, 5'd0, 7'h0);
        tick();
        idle();
        halt = 1'b1;
        disp(0, 5'd5, 5'd0, 1'b1, 5'd9, 7'h40);
        disp(1, 5'd5, 5'd5, 1'b0, 5'd0, 7'h0);
        commit(0, 5'd7, 7'h21, 32'h77);
        tick();
        n_cmp++;
        if (out_valid !== 2'b01 || rs1_ready[0] !== 1'b0 || rs1_tag[6:0] !== 7'h21) begin
            n_fail++; $display("FAIL halt_hold: got v=%b rdy=%b tag=%h want v=01 rdy=0 tag=21", out_valid, rs1_ready[0], rs1_tag[6:0]);
        end
        idle();
        disp(0, 5'd9, 5'd7, 1'b0, 5'd0, 7'h0);
        tick();
        n_cmp++;
        if (rs1_ready[0] !== 1'b1) begin n_fail++; $display("FAIL halt_no_rename: got rdy=%b want 1", rs1_ready[0]); end
        n_cmp++;
        if (rs2_ready[0] !== 1'b1 || rs2_data[31:0] !== 32'h77) begin
            n_fail++; $display("FAIL halt_commit: got rdy=%b data=%h want rdy=1 data=77", rs2_ready[0], rs2_data[31:0]);
        end
    endtask

    task automatic test_flush;
        idle();
        disp(0, 5'd0, 5'd0, 1'b1, 5'd10, 7'h01);
        disp(1, 5'd0, 5'd0, 1'b1, 5'd11, 7'h02);
        tick();
        idle();
        disp(0, 5'd0, 5'd0, 1'b1, 5'd12, 7'h03);
        disp(1, 5'd10, 5'd0, 1'b0, 5'd0, 7'h0);
        tick();
        n_cmp++;
        if (rs1_ready[1] !== 1'b0 || rs1_tag[13:7] !== 7'h01) begin
            n_fail++; $display("FAIL flush_pre_busy: got rdy=%b tag=%h want rdy=0 tag=01", rs1_ready[1], rs1_tag[13:7]);
        end
        idle();
        flush = 1'b1;
        disp(0, 5'd10, 5'd0, 1'b1, 5'd13, 7'h04);
        commit(0, 5'd12, 7'h55, 32'hABCD);
        tick();
        n_cmp++;
        if (out_valid !== 2'b00) begin n_fail++; $display("FAIL flush_valid: got %b want 00", out_valid); end
        idle();
        disp(0, 5'd10, 5'd11, 1'b0, 5'd0, 7'h0);
        disp(1, 5'd12, 5'd13, 1'b0, 5'd0, 7'h0);
        tick();
        n_cmp++;
        if ({rs1_ready, rs2_ready} !== 4'b1111) begin
            n_fail++; $display("FAIL flush_all_ready: got %b want 1111", {rs1_ready, rs2_ready});
        end
        n_cmp++;
        if (rs1_data[63:32] !== 32'hABCD || rs2_data[63:32] !== 32'h0) begin
            n_fail++; $display("FAIL flush_data: got x12=%h x13=%h want x12=abcd x13=0", rs1_data[63:32], rs2_data[63:32]);
        end
    endtask

    task automatic test_cdb;
        idle();
        disp(0, 5'd0, 5'd0, 1'b1, 5'd14, 7'h20);
        tick();
        idle();
        disp(1, 5'd0, 5'd14, 1'b0, 5'd0, 7'h0);
        cdb_valid = 1'b1; cdb_tag = 7'h20; cdb_data = 32'h55;
        tick();
        n_cmp++;
`ifdef RF_CDB_BYPASS_EN
        if (rs2_ready[1] !== 1'b1 || rs2_data[63:32] !== 32'h55) begin
            n_fail++; $display("FAIL cdb_read_bypass: got rdy=%b data=%h want rdy=1 data=55", rs2_ready[1], rs2_data[63:32]);
        end
`else
        if (rs2_ready[1] !== 1'b0 || rs2_tag[13:7] !== 7'h20) begin
            n_fail++; $display("FAIL cdb_ignored: got rdy=%b tag=%h want rdy=0 tag=20", rs2_ready[1], rs2_tag[13:7]);
        end
`endif
        idle();
        disp(1, 5'd0, 5'd14, 1'b0, 5'd0, 7'h0);
        tick();
        n_cmp++;
        if (rs2_ready[1] !== 1'b0 || rs2_tag[13:7] !== 7'h20) begin
            n_fail++; $display("FAIL cdb_pre_sticky: got rdy=%b tag=%h want rdy=0 tag=20", rs2_ready[1], rs2_tag[13:7]);
        end
        idle();
        halt = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 7'h20; cdb_data = 32'h66;
        tick();
        n_cmp++;
`ifdef RF_CDB_BYPASS_EN
        if (rs2_ready[1] !== 1'b1 || rs2_data[63:32] !== 32'h66) begin
            n_fail++; $display("FAIL cdb_sticky: got rdy=%b data=%h want rdy=1 data=66", rs2_ready[1], rs2_data[63:32]);
        end
`else
        if (rs2_ready[1] !== 1'b0) begin
            n_fail++; $display("FAIL cdb_halt_ignored: got rdy=%b want 0", rs2_ready[1]);
        end
`endif
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_rename();
        test_commit();
        test_stale_commit();
        test_bundle();
        test_halt();
        test_flush();
        test_cdb();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
